bsg_mcl_host_packetizer: RTL and testbench
==========================================

Name: bsg_mcl_host_packetizer

Overview:
Host-side end of the manycore-link FIFO interface. It packs a 32-bit host word stream into 128-bit request/response packets for the endpoint bridge's fifo_*_i inputs. It buffers 128-bit packets arriving from the bridge's fifo_*_o outputs and serializes them back to 32-bit host words. It also reports receive-buffer vacancy, which the bridge uses to throttle host load requests. One instance serves one FIFO channel; the top level instantiates 2*num_endpoint_p copies.

Parameters:
fifo_width_p, 128, packet width; must be an integer multiple of host_width_p.
host_width_p, 32, host word width.
rx_els_p, 16, receive buffer depth in packets; minimum 2.
(derived) words_lp = fifo_width_p/host_width_p; cnt_w_lp = `BSG_WIDTH(rx_els_p).

Ports:
clk_i  in  1  clock.
reset_i  in  1  synchronous active-high reset.
host_v_i  in  1  host TX word valid.
host_data_i  in  host_width_p  host TX word.
host_ready_o  out  1  TX word accepted when host_v_i & host_ready_o.
flush_i  in  1  discard partially assembled TX packet.
tx_v_o  out  1  assembled packet valid (to bridge fifo_v_i).
tx_data_o  out  fifo_width_p  assembled packet.
tx_ready_i  in  1  bridge accepts packet.
rx_v_i  in  1  packet from bridge valid.
rx_data_i  in  fifo_width_p  packet from bridge.
rx_ready_o  out  1  buffer has space.
host_v_o  out  1  RX word valid.
host_data_o  out  host_width_p  RX word.
host_yumi_i  in  1  host consumes RX word; legal only when host_v_o=1.
rx_vacancy_o  out  cnt_w_lp  free packet slots (to bridge rcv_fifo_vacancy_i).
tx_word_cnt_o  out  `BSG_WIDTH(words_lp)  words held in the partial TX packet.

Behaviour:
Reset values:
- tx_v_o=0, tx_word_cnt_o=0, host_v_o=0.
- rx_ready_o=1, rx_vacancy_o=rx_els_p.
- Data outputs are don't-care while their valid is low.

TX packer:
- Word k of a packet (k=0 first) lands in tx_data_o[k*host_width_p +: host_width_p].
- host_ready_o = ~flush_i & (~tx_v_o | tx_ready_i).
- Each accepted word increments the word counter.
- On the accepted word with counter = words_lp-1: counter wraps to 0 and tx_v_o=1 from the next cycle. Latency is 1 cycle from last word to tx_v_o.
- tx_v_o holds with stable tx_data_o until tx_ready_i.
- If tx_ready_i and a new word 0 are accepted in the same cycle, the old packet departs and the new word is captured. There is no bubble.

flush_i:
- Clears the word counter only. It never drops a completed packet: tx_v_o and tx_data_o are unaffected.
- It blocks host word acceptance that cycle.

RX buffer:
- Circular buffer of rx_els_p entries with write pointer, read pointer, and count. Pointers wrap at rx_els_p, including non-power-of-2 depths.
- rx_ready_o = (count != rx_els_p), computed from registered count only. When full, a simultaneous pop does not enable a push that cycle.
- Push on rx_v_i & rx_ready_o.
- Simultaneous push and pop leaves count unchanged.
- rx_vacancy_o = rx_els_p - count, registered-equivalent.

RX serializer:
- host_v_o = (count != 0).
- host_data_o = head[idx*host_width_p +: host_width_p], where idx is the word index.
- On host_yumi_i, idx increments. At idx = words_lp-1, idx returns to 0 and the head packet is popped.
- A packet pushed into an empty buffer is visible on host_v_o the next cycle (1-cycle latency).
- host_yumi_i while host_v_o=0 is illegal; the design asserts in simulation.

Reset mid-operation:
- Partial TX packet, pending tx_v_o, buffered RX packets, and the serializer index are all discarded.
- Outputs return to reset values the cycle after reset_i is sampled high.

Optional Feature:
Macro BSG_MCL_HOST_PACKETIZER_COUNT_EN.
- Defined:
  - Adds outputs tx_pkt_count_o[31:0] and rx_pkt_count_o[31:0].
  - tx_pkt_count_o increments per tx_v_o & tx_ready_i; rx_pkt_count_o increments per RX push.
  - Both saturate at 32'hFFFF_FFFF and clear on reset_i.
  - Host uses them for debug/progress checks.
- Undefined:
  - Ports and counters are absent.
  - All other behaviour is identical.

Test Plan:
1. Reset, then push words 11111111, 22222222, 33333333, 44444444 with tx_ready_i=1 -> 1 cycle after word 3, tx_v_o=1 with tx_data_o=128'h44444444_33333333_22222222_11111111 for one cycle; tx_word_cnt_o returns to 0.
2. tx_ready_i=0 with a completed packet pending, host keeps host_v_i=1 -> host_ready_o=0 and tx_data_o stable. Raise tx_ready_i while the next word is valid -> packet departs and the new word is captured in the same cycle.
3. Push 2 words, assert flush_i for 1 cycle, then push 4 fresh words -> the emitted packet contains only the 4 fresh words; tx_word_cnt_o goes 2 -> 0 on flush.
4. rx_els_p=16: push 16 packets with host_yumi_i=0 -> rx_ready_o=0 and rx_vacancy_o=0. Then rx_v_i=1 held and 4 yumis drain one packet -> rx_ready_o rises the cycle after the pop; vacancy reaches 1, then 0 again after the refill push.
5. Push packet 128'hDDDD0000_CCCC0000_BBBB0000_AAAA0000 into an empty buffer, host_yumi_i=1 continuously -> host_data_o sequence AAAA0000, BBBB0000, CCCC0000, DDDD0000; host_v_o falls after the 4th word.
6. Assert reset_i with 3 RX packets buffered and 2 TX words held -> next cycle host_v_o=0, rx_vacancy_o=16, tx_word_cnt_o=0. With COUNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/bsg_mcl_host_packetizer.sv
// Host-side FIFO channel end: packs 32-bit host words into link packets and serializes received packets back.
// Define BSG_MCL_HOST_PACKETIZER_COUNT_EN to add saturating TX/RX packet counters.
module bsg_mcl_host_packetizer #(
  parameter int fifo_width_p = 128,
  parameter int host_width_p = 32,
  parameter int rx_els_p     = 16,
  localparam int words_lp    = fifo_width_p / host_width_p,
  localparam int cnt_w_lp    = $clog2(rx_els_p + 1),
  localparam int wcnt_w_lp   = $clog2(words_lp + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,

  input  logic                    host_v_i,
  input  logic [host_width_p-1:0] host_data_i,
  output logic                    host_ready_o,
  input  logic                    flush_i,

  output logic                    tx_v_o,
  output logic [fifo_width_p-1:0] tx_data_o,
  input  logic                    tx_ready_i,

  input  logic                    rx_v_i,
  input  logic [fifo_width_p-1:0] rx_data_i,
  output logic                    rx_ready_o,

  output logic                    host_v_o,
  output logic [host_width_p-1:0] host_data_o,
  input  logic                    host_yumi_i,

  output logic [cnt_w_lp-1:0]     rx_vacancy_o,
`ifdef BSG_MCL_HOST_PACKETIZER_COUNT_EN
  output logic [31:0]             tx_pkt_count_o,
  output logic [31:0]             rx_pkt_count_o,
`endif
  output logic [wcnt_w_lp-1:0]    tx_word_cnt_o
);

  localparam int idx_w_lp = (words_lp > 1) ? $clog2(words_lp) : 1;
  localparam int ptr_w_lp = $clog2(rx_els_p);

  // ---------------- TX packer ----------------
  logic [wcnt_w_lp-1:0]    tx_cnt_r;
  logic [fifo_width_p-1:0] tx_asm_r;
  logic [fifo_width_p-1:0] tx_asm_next;
  logic [fifo_width_p-1:0] tx_data_r;
  logic                    tx_v_r;
  logic                    host_accept;
  logic                    tx_last;

  assign host_ready_o = ~flush_i & (~tx_v_r | tx_ready_i);
  assign host_accept  = host_v_i & host_ready_o;
  assign tx_last      = (tx_cnt_r == wcnt_w_lp'(words_lp - 1));

  always_comb begin
    tx_asm_next = tx_asm_r;
    for (int k = 0; k < words_lp; k++) begin
      if (tx_cnt_r == wcnt_w_lp'(k))
        tx_asm_next[k*host_width_p +: host_width_p] = host_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_cnt_r <= '0;
      tx_v_r   <= 1'b0;
    end else begin
      if (flush_i)
        tx_cnt_r <= '0;
      else if (host_accept)
        tx_cnt_r <= tx_last ? '0 : tx_cnt_r + wcnt_w_lp'(1);

      // a departing packet and a newly completed one in the same cycle keep valid high
      if (host_accept & tx_last)
        tx_v_r <= 1'b1;
      else if (tx_ready_i)
        tx_v_r <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (host_accept)
      tx_asm_r <= tx_asm_next;
    if (host_accept & tx_last)
      tx_data_r <= tx_asm_next;
  end

  assign tx_v_o        = tx_v_r;
  assign tx_data_o     = tx_data_r;
  assign tx_word_cnt_o = tx_cnt_r;

  // ---------------- RX buffer and serializer ----------------
  logic [fifo_width_p-1:0] rx_mem_r [rx_els_p];
  logic [ptr_w_lp-1:0]     wptr_r;
  logic [ptr_w_lp-1:0]     rptr_r;
  logic [cnt_w_lp-1:0]     rx_cnt_r;
  logic [idx_w_lp-1:0]     idx_r;
  logic [fifo_width_p-1:0] rx_head;
  logic                    rx_push;
  logic                    rx_pop;
  logic                    host_take;
  logic                    idx_last;

  assign rx_ready_o   = (rx_cnt_r != cnt_w_lp'(rx_els_p));
  assign host_v_o     = (rx_cnt_r != '0);
  assign rx_vacancy_o = cnt_w_lp'(rx_els_p) - rx_cnt_r;

  assign rx_push   = rx_v_i & rx_ready_o;
  assign host_take = host_yumi_i & host_v_o;
  assign idx_last  = (idx_r == idx_w_lp'(words_lp - 1));
  assign rx_pop    = host_take & idx_last;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r   <= '0;
      rptr_r   <= '0;
      rx_cnt_r <= '0;
      idx_r    <= '0;
    end else begin
      if (rx_push)
        wptr_r <= (wptr_r == ptr_w_lp'(rx_els_p - 1)) ? '0 : wptr_r + ptr_w_lp'(1);
      if (rx_pop)
        rptr_r <= (rptr_r == ptr_w_lp'(rx_els_p - 1)) ? '0 : rptr_r + ptr_w_lp'(1);
      if (host_take)
        idx_r <= idx_last ? '0 : idx_r + idx_w_lp'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_r <= rx_cnt_r + cnt_w_lp'(1);
        2'b01:   rx_cnt_r <= rx_cnt_r - cnt_w_lp'(1);
        default: rx_cnt_r <= rx_cnt_r;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rx_push)
      rx_mem_r[wptr_r] <= rx_data_i;
  end

  assign rx_head = rx_mem_r[rptr_r];

  always_comb begin
    host_data_o = rx_head[host_width_p-1:0];
    for (int k = 0; k < words_lp; k++) begin
      if (idx_r == idx_w_lp'(k))
        host_data_o = rx_head[k*host_width_p +: host_width_p];
    end
  end

`ifdef BSG_MCL_HOST_PACKETIZER_COUNT_EN
  logic [31:0] tx_pkt_cnt_r;
  logic [31:0] rx_pkt_cnt_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_pkt_cnt_r <= '0;
      rx_pkt_cnt_r <= '0;
    end else begin
      if (tx_v_r & tx_ready_i & ~(&tx_pkt_cnt_r))
        tx_pkt_cnt_r <= tx_pkt_cnt_r + 32'd1;
      if (rx_push & ~(&rx_pkt_cnt_r))
        rx_pkt_cnt_r <= rx_pkt_cnt_r + 32'd1;
    end
  end

  assign tx_pkt_count_o = tx_pkt_cnt_r;
  assign rx_pkt_count_o = rx_pkt_cnt_r;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i)
      assert (!(host_yumi_i && !host_v_o))
        else $error("host_yumi_i asserted while host_v_o is low");
  end
`endif

endmodule

// File: tb/tb_bsg_mcl_host_packetizer.sv
// Directed bench for bsg_mcl_host_packetizer: TX vector table plus RX/reset sequences.
module tb_bsg_mcl_host_packetizer;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         host_v_i;
  logic [31:0]  host_data_i;
  logic         host_ready_o;
  logic         flush_i;
  logic         tx_v_o;
  logic [127:0] tx_data_o;
  logic         tx_ready_i;
  logic         rx_v_i;
  logic [127:0] rx_data_i;
  logic         rx_ready_o;
  logic         host_v_o;
  logic [31:0]  host_data_o;
  logic         host_yumi_i;
  logic [4:0]   rx_vacancy_o;
  logic [2:0]   tx_word_cnt_o;
`ifdef BSG_MCL_HOST_PACKETIZER_COUNT_EN
  logic [31:0]  tx_pkt_count_o;
  logic [31:0]  rx_pkt_count_o;
`endif

  always #5 clk_i = ~clk_i;

  bsg_mcl_host_packetizer dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .host_v_i     (host_v_i),
    .host_data_i  (host_data_i),
    .host_ready_o (host_ready_o),
    .flush_i      (flush_i),
    .tx_v_o       (tx_v_o),
    .tx_data_o    (tx_data_o),
    .tx_ready_i   (tx_ready_i),
    .rx_v_i       (rx_v_i),
    .rx_data_i    (rx_data_i),
    .rx_ready_o   (rx_ready_o),
    .host_v_o     (host_v_o),
    .host_data_o  (host_data_o),
    .host_yumi_i  (host_yumi_i),
    .rx_vacancy_o (rx_vacancy_o),
`ifdef BSG_MCL_HOST_PACKETIZER_COUNT_EN
    .tx_pkt_count_o (tx_pkt_count_o),
    .rx_pkt_count_o (rx_pkt_count_o),
`endif
    .tx_word_cnt_o (tx_word_cnt_o)
  );

  typedef struct {
    logic         v;
    logic [31:0]  d;
    logic         fl;
    logic         rdy;
    logic         exp_ready;
    logic         exp_tv;
    logic [127:0] exp_td;
    logic [2:0]   exp_cnt;
  } tx_vec_t;

  int errors = 0;
  int checks = 0;
  tx_vec_t tv [21];

  localparam logic [127:0] P1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] P2 = 128'hA0000004_A0000003_A0000002_A0000001;
  localparam logic [127:0] P3 = 128'hC0000004_C0000003_C0000002_C0000001;
  localparam logic [127:0] PX = 128'h0;

  function automatic tx_vec_t mk(logic v, logic [31:0] d, logic fl, logic rdy,
                                 logic er, logic etv, logic [127:0] etd, logic [2:0] ec);
    tx_vec_t r;
    r.v = v; r.d = d; r.fl = fl; r.rdy = rdy;
    r.exp_ready = er; r.exp_tv = etv; r.exp_td = etd; r.exp_cnt = ec;
    return r;
  endfunction

  function automatic logic [31:0] wd(int n);
    return 32'h5EED0000 + 32'(n);
  endfunction

  function automatic logic [127:0] pk(int base);
    return {wd(base + 3), wd(base + 2), wd(base + 1), wd(base)};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; host_v_i = 1'b0; host_data_i = '0; flush_i = 1'b0;
    tx_ready_i = 1'b0; rx_v_i = 1'b0; rx_data_i = '0; host_yumi_i = 1'b0;

    //          v     data           fl    rdy   ready tv    td  cnt
    tv[0]  = mk(1'b1, 32'h11111111, 1'b0, 1'b1, 1'b1, 1'b0, PX, 3'd1);
    tv[1]  = mk(1'b1, 32'h22222222, 1'b0, 1'b1, 1'b1, 1'b0, PX, 3'd2);
    tv[2]  = mk(1'b1, 32'h33333333, 1'b0, 1'b1, 1'b1, 1'b0, PX, 3'd3);
    tv[3]  = mk(1'b1, 32'h44444444, 1'b0, 1'b1, 1'b1, 1'b1, P1, 3'd0);
    tv[4]  = mk(1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, PX, 3'd0);
    tv[5]  = mk(1'b1, 32'hA0000001, 1'b0, 1'b0, 1'b1, 1'b0, PX, 3'd1);
    tv[6]  = mk(1'b1, 32'hA0000002, 1'b0, 1'b0, 1'b1, 1'b0, PX, 3'd2);
    tv[7]  = mk(1'b1, 32'hA0000003, 1'b0, 1'b0, 1'b1, 1'b0, PX, 3'd3);
    tv[8]  = mk(1'b1, 32'hA0000004, 1'b0, 1'b0, 1'b1, 1'b1, P2, 3'd0);
    tv[9]  = mk(1'b1, 32'hB0000001, 1'b0, 1'b0, 1'b0, 1'b1, P2, 3'd0);
    tv[10] = mk(1'b1, 32'hB0000001, 1'b0, 1'b0, 1'b0, 1'b1, P2, 3'd0);
    tv[11] = mk(1'b1, 32'hB0000001, 1'b0, 1'b1, 1'b1, 1'b0, PX, 3'd1);
    tv[12] = mk(1'b1, 32'hB0000002, 1'b0, 1'b1, 1'b1, 1'b0, PX, 3'd2);
    tv[13] = mk(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0, PX, 3'd0);
    tv[14] = mk(1'b1, 32'hC0000001, 1'b0, 1'b1, 1'b1, 1'b0, PX, 3'd1);
    tv[15] = mk(1'b1, 32'hC0000002, 1'b0, 1'b1, 1'b1, 1'b0, PX, 3'd2);
    tv[16] = mk(1'b1, 32'hC0000003, 1'b0, 1'b1, 1'b1, 1'b0, PX, 3'd3);
    tv[17] = mk(1'b1, 32'hC0000004, 1'b0, 1'b1, 1'b1, 1'b1, P3, 3'd0);
    tv[18] = mk(1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, P3, 3'd0);
    tv[19] = mk(1'b1, 32'hD0000001, 1'b0, 1'b1, 1'b1, 1'b0, PX, 3'd1);
    tv[20] = mk(1'b1, 32'hD0000002, 1'b1, 1'b0, 1'b0, 1'b0, PX, 3'd0);

    cyc();
    cyc();
    chk("rst_tx_v", tx_v_o, 1'b0);
    chk("rst_tx_cnt", tx_word_cnt_o, 3'd0);
    chk("rst_host_v", host_v_o, 1'b0);
    chk("rst_rx_ready", rx_ready_o, 1'b1);
    chk("rst_vacancy", rx_vacancy_o, 5'd16);
    reset_i = 1'b0;

    // TX packing, backpressure, and flush vectors
    for (int i = 0; i < 21; i++) begin
      host_v_i = tv[i].v; host_data_i = tv[i].d; flush_i = tv[i].fl; tx_ready_i = tv[i].rdy;
      #1;
      chk($sformatf("tx%0d_host_ready", i), host_ready_o, tv[i].exp_ready);
      cyc();
      chk($sformatf("tx%0d_tx_v", i), tx_v_o, tv[i].exp_tv);
      if (tv[i].exp_tv)
        chk($sformatf("tx%0d_tx_data", i), tx_data_o, tv[i].exp_td);
      chk($sformatf("tx%0d_word_cnt", i), tx_word_cnt_o, tv[i].exp_cnt);
    end
    host_v_i = 1'b0; flush_i = 1'b0; tx_ready_i = 1'b1;
    cyc();

    // Single packet into empty buffer, continuous yumi
    rx_v_i = 1'b1; rx_data_i = 128'hDDDD0000_CCCC0000_BBBB0000_AAAA0000;
    cyc();
    rx_v_i = 1'b0;
    chk("rx1_host_v_latency", host_v_o, 1'b1);
    chk("rx1_vacancy", rx_vacancy_o, 5'd15);
    host_yumi_i = 1'b1;
    chk("rx1_w0", host_data_o, 32'hAAAA0000);
    cyc();
    chk("rx1_w1", host_data_o, 32'hBBBB0000);
    cyc();
    chk("rx1_w2", host_data_o, 32'hCCCC0000);
    cyc();
    chk("rx1_w3", host_data_o, 32'hDDDD0000);
    chk("rx1_v_before_last", host_v_o, 1'b1);
    cyc();
    host_yumi_i = 1'b0;
    chk("rx1_host_v_fall", host_v_o, 1'b0);
    chk("rx1_vacancy_empty", rx_vacancy_o, 5'd16);

    // Fill to full, drain one with rx_v held, refill, then drain all (pointer wrap)
    rx_v_i = 1'b1;
    for (int p = 0; p < 16; p++) begin
      rx_data_i = pk(p * 4);
      cyc();
    end
    chk("full_rx_ready", rx_ready_o, 1'b0);
    chk("full_vacancy", rx_vacancy_o, 5'd0);
    rx_data_i = pk(64);
    host_yumi_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("full_head_w%0d", k), host_data_o, wd(k));
      chk($sformatf("full_ready_hold%0d", k), rx_ready_o, 1'b0);
      cyc();
    end
    host_yumi_i = 1'b0;
    chk("pop_rx_ready_rise", rx_ready_o, 1'b1);
    chk("pop_vacancy", rx_vacancy_o, 5'd1);
    cyc();
    rx_v_i = 1'b0;
    chk("refill_vacancy", rx_vacancy_o, 5'd0);
    chk("refill_rx_ready", rx_ready_o, 1'b0);
    host_yumi_i = 1'b1;
    for (int p = 1; p <= 16; p++) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("drain_p%0d_w%0d", p, k), host_data_o, wd(p * 4 + k));
        cyc();
      end
    end
    host_yumi_i = 1'b0;
    chk("drain_host_v", host_v_o, 1'b0);
    chk("drain_vacancy", rx_vacancy_o, 5'd16);

    // Reset mid-operation
    rx_v_i = 1'b1;
    for (int p = 0; p < 3; p++) begin
      rx_data_i = pk(100 + p * 4);
      cyc();
    end
    rx_v_i = 1'b0;
    host_v_i = 1'b1; tx_ready_i = 1'b1;
    host_data_i = 32'h77770001;
    cyc();
    host_data_i = 32'h77770002;
    cyc();
    host_v_i = 1'b0;
    chk("pre_rst_vacancy", rx_vacancy_o, 5'd13);
    chk("pre_rst_cnt", tx_word_cnt_o, 3'd2);
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    chk("mid_rst_host_v", host_v_o, 1'b0);
    chk("mid_rst_vacancy", rx_vacancy_o, 5'd16);
    chk("mid_rst_cnt", tx_word_cnt_o, 3'd0);
    chk("mid_rst_rx_ready", rx_ready_o, 1'b1);
    chk("mid_rst_tx_v", tx_v_o, 1'b0);
`ifdef BSG_MCL_HOST_PACKETIZER_COUNT_EN
    chk("mid_rst_tx_pkt_count", tx_pkt_count_o, 32'd0);
    chk("mid_rst_rx_pkt_count", rx_pkt_count_o, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
